riscv_div_rem_unit: RTL and testbench
=====================================

Name: riscv_div_rem_unit

Overview:
- Iterative 32-bit integer divide/remainder responder for the EX stage.
- Accepts ALU_DIVU / ALU_DIV / ALU_REMU / ALU_REM requests issued by the ALU/decoder path.
- Computes one quotient bit per cycle, then holds the result until the EX stage accepts it.
- Sits beside the ALU. The ALU issues the request, stalls on ready_o, and consumes result_o on valid_o.

Parameters:
- DATA_WIDTH, 32, operand/result width; only 32 is supported.
- CNT_WIDTH, 5, iteration counter width; equals log2(DATA_WIDTH).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- enable_i  in  1  request valid
- operator_i  in  ALU_OP_WIDTH(7)  ALU operation code; bit0 = signed, bit1 = remainder
- operand_a_i  in  32  dividend
- operand_b_i  in  32  divisor
- kill_i  in  1  abort the in-flight operation (pipeline flush)
- ex_ready_i  in  1  EX stage accepts the result this cycle
- ready_o  out  1  unit idle; a request can be accepted
- valid_o  out  1  result_o valid
- result_o  out  32  quotient or remainder

Behaviour:
- Accept condition: enable_i & ready_o & (operator_i[6:2] == 5'b01100). Any other operator is ignored; the unit stays in IDLE.
- Reset values: state = IDLE, ready_o = 1, valid_o = 0, result_o = 0, counter = 0, all datapath registers = 0.
- FSM states: IDLE, CALC, DONE.
- IDLE -> CALC on a normal accept. Latch the following:
  - |a| and |b| (magnitude only when signed);
  - negate_q = signed & (a[31] ^ b[31]);
  - negate_r = signed & a[31];
  - rem_sel = operator_i[1];
  - counter = 31.
- IDLE -> DONE directly on a special case:
  - Divisor zero: quotient = 32'hFFFF_FFFF, remainder = operand_a_i, for both signed and unsigned.
  - Signed overflow (a = 32'h8000_0000, b = 32'hFFFF_FFFF): quotient = 32'h8000_0000, remainder = 0.
- CALC: restoring shift-subtract, one bit per cycle.
  - {rem, quo} shift left by 1.
  - If rem >= |b|, then rem -= |b| and quo[0] = 1.
  - Comparison is a 33-bit unsigned subtract.
  - The counter decrements each cycle. When the counter is 0, go to DONE.
- Final sign fix on entry to DONE:
  - result = rem_sel ? (negate_r ? -rem : rem) : (negate_q ? -quo : quo).
  - result_o is registered.
- DONE: valid_o = 1 and result_o is held stable.
  - ex_ready_i = 1 -> IDLE in the next cycle.
  - ex_ready_i = 0 -> remain in DONE (backpressure).
- Latency, with acceptance at cycle N:
  - Normal path: valid_o first high at cycle N+33.
  - Special cases: valid_o first high at cycle N+1.
- ready_o = 1 only in IDLE. A new request cannot be accepted in the same cycle a DONE result is consumed.
- kill_i:
  - In CALC or DONE: state goes to IDLE in the next cycle and valid_o drops. The result is discarded; no valid_o is ever produced for the killed operation.
  - In IDLE: blocks acceptance that cycle.
  - kill_i has priority over ex_ready_i and over accept.
- enable_i while busy: ignored. The requester must hold the request until ready_o.
- Asynchronous reset mid-operation: immediately returns to the reset values. No partial result is ever flagged valid.
- Operand changes after acceptance: no effect; all operands are latched at accept.

Decomposition:
- Shared package riscv_defines receives:
  - typedef enum logic[1:0] div_state_t {DIV_IDLE, DIV_CALC, DIV_DONE};
  - constant DIV_OP_PREFIX = 5'b01100.
- ALU_DIV* codes already live in riscv_defines and are reused unchanged.
- One natural sub-module: riscv_div_negate, a combinational conditional two's-complement of a 32-bit value. It is instantiated for operand magnitude and for the result sign fix.

Test Plan:
- DIVU 100 / 7, ex_ready_i held 1 -> valid_o at N+33, result_o = 14; ready_o high at N+34.
- REM a = 32'hFFFF_FFF9 (-7), b = 2 -> result_o = 32'hFFFF_FFFF (-1). DIV with the same operands -> 32'hFFFF_FFFD (-3).
- Divide by zero:
  - DIV 55 / 0 -> result_o = 32'hFFFF_FFFF at N+1.
  - REMU 55 / 0 -> result_o = 55 at N+1.
- Signed overflow:
  - DIV 32'h8000_0000 / 32'hFFFF_FFFF -> 32'h8000_0000 at N+1.
  - REM with the same operands -> 0.
- Backpressure: DIVU 1000 / 10 with ex_ready_i = 0 for 5 cycles after valid_o -> result_o = 100 stable and valid_o high throughout; IDLE one cycle after ex_ready_i rises.
- Abort and reset:
  - kill_i pulsed at N+10 -> valid_o never asserted, ready_o = 1 at N+11.
  - rst_n asserted low at N+20 -> all outputs at reset values immediately.
  - A subsequent REMU 17 / 5 returns 2.

Source files
------------

// File: rtl/riscv_defines.sv
// Shared core definitions: ALU operation codes plus the divider state encoding.
package riscv_defines;

    localparam int ALU_OP_WIDTH = 7;

    localparam logic [ALU_OP_WIDTH-1:0] ALU_DIVU = 7'b0110000;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_DIV  = 7'b0110001;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_REMU = 7'b0110010;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_REM  = 7'b0110011;

    localparam logic [4:0] DIV_OP_PREFIX = 5'b01100;

    typedef enum logic [1:0] {DIV_IDLE, DIV_CALC, DIV_DONE} div_state_t;

endpackage

// File: rtl/riscv_div_negate.sv
// Conditional two's-complement: result = neg ? -value : value.
module riscv_div_negate #(
    parameter int WIDTH = 32
) (
    input  logic             neg,
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] result
);

    assign result = neg ? (~value + {{(WIDTH-1){1'b0}}, 1'b1}) : value;

endmodule

// File: rtl/riscv_div_rem_unit.sv
// Iterative 32-bit DIV/DIVU/REM/REMU unit: restoring division, one quotient bit per cycle,
// result held in DONE until the EX stage takes it.
module riscv_div_rem_unit
    import riscv_defines::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable_i,
    input  logic [ALU_OP_WIDTH-1:0] operator_i,
    input  logic [DATA_WIDTH-1:0]   operand_a_i,
    input  logic [DATA_WIDTH-1:0]   operand_b_i,
    input  logic                    kill_i,
    input  logic                    ex_ready_i,
    output logic                    ready_o,
    output logic                    valid_o,
    output logic [DATA_WIDTH-1:0]   result_o
);

    localparam logic [DATA_WIDTH-1:0] INT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    div_state_t             state;
    logic [CNT_WIDTH-1:0]   counter;
    logic [DATA_WIDTH-1:0]  rem_q, quo_q, divisor_q;
    logic                   neg_quo_q, neg_rem_q, rem_sel_q;

    logic                   is_signed, accept, div_zero, overflow;
    logic [DATA_WIDTH-1:0]  a_abs, b_abs, special_res;
    logic [DATA_WIDTH:0]    rem_sh, diff;
    logic                   ge;
    logic [DATA_WIDTH-1:0]  rem_nxt, quo_nxt, fix_val, fix_res;

    assign is_signed = operator_i[0];
    assign accept    = enable_i & ready_o & ~kill_i & (operator_i[6:2] == DIV_OP_PREFIX);
    assign div_zero  = (operand_b_i == '0);
    assign overflow  = is_signed & (operand_a_i == INT_MIN) & (operand_b_i == '1);

    // Divide-by-zero wins over overflow; the remainder of x/0 is x unchanged.
    assign special_res = div_zero ? (operator_i[1] ? operand_a_i : '1)
                                  : (operator_i[1] ? '0 : INT_MIN);

    riscv_div_negate #(.WIDTH(DATA_WIDTH)) u_abs_a (
        .neg(is_signed & operand_a_i[DATA_WIDTH-1]), .value(operand_a_i), .result(a_abs));
    riscv_div_negate #(.WIDTH(DATA_WIDTH)) u_abs_b (
        .neg(is_signed & operand_b_i[DATA_WIDTH-1]), .value(operand_b_i), .result(b_abs));

    // rem < divisor keeps rem_sh < 2*divisor, so bit DATA_WIDTH of the difference is the borrow.
    assign rem_sh  = {rem_q, quo_q[DATA_WIDTH-1]};
    assign diff    = rem_sh - {1'b0, divisor_q};
    assign ge      = ~diff[DATA_WIDTH];
    assign rem_nxt = ge ? diff[DATA_WIDTH-1:0] : rem_sh[DATA_WIDTH-1:0];
    assign quo_nxt = {quo_q[DATA_WIDTH-2:0], ge};
    assign fix_val = rem_sel_q ? rem_nxt : quo_nxt;

    riscv_div_negate #(.WIDTH(DATA_WIDTH)) u_fix (
        .neg(rem_sel_q ? neg_rem_q : neg_quo_q), .value(fix_val), .result(fix_res));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= DIV_IDLE;
            counter   <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            rem_sel_q <= 1'b0;
            ready_o   <= 1'b1;
            valid_o   <= 1'b0;
            result_o  <= '0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (accept) begin
                        ready_o <= 1'b0;
                        if (div_zero || overflow) begin
                            state    <= DIV_DONE;
                            valid_o  <= 1'b1;
                            result_o <= special_res;
                        end else begin
                            state     <= DIV_CALC;
                            rem_q     <= '0;
                            quo_q     <= a_abs;
                            divisor_q <= b_abs;
                            neg_quo_q <= is_signed & (operand_a_i[DATA_WIDTH-1] ^ operand_b_i[DATA_WIDTH-1]);
                            neg_rem_q <= is_signed & operand_a_i[DATA_WIDTH-1];
                            rem_sel_q <= operator_i[1];
                            counter   <= '1;
                        end
                    end
                end
                DIV_CALC: begin
                    if (kill_i) begin
                        state   <= DIV_IDLE;
                        ready_o <= 1'b1;
                    end else begin
                        rem_q <= rem_nxt;
                        quo_q <= quo_nxt;
                        if (counter == '0) begin
                            state    <= DIV_DONE;
                            valid_o  <= 1'b1;
                            result_o <= fix_res;
                        end else begin
                            counter <= counter - 1'b1;
                        end
                    end
                end
                DIV_DONE: begin
                    if (kill_i || ex_ready_i) begin
                        state   <= DIV_IDLE;
                        valid_o <= 1'b0;
                        ready_o <= 1'b1;
                    end
                end
                default: begin
                    state   <= DIV_IDLE;
                    valid_o <= 1'b0;
                    ready_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_div_rem_unit.sv
// Directed bench for riscv_div_rem_unit: latency, results, special cases, backpressure, kill, reset.
module tb_riscv_div_rem_unit;
    import riscv_defines::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable_i;
    logic [6:0]  operator_i;
    logic [31:0] operand_a_i, operand_b_i;
    logic        kill_i, ex_ready_i;
    logic        ready_o, valid_o;
    logic [31:0] result_o;

    int total = 0;
    int bad   = 0;
    int lat;

    riscv_div_rem_unit dut (
        .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .operator_i(operator_i),
        .operand_a_i(operand_a_i), .operand_b_i(operand_b_i), .kill_i(kill_i),
        .ex_ready_i(ex_ready_i), .ready_o(ready_o), .valid_o(valid_o), .result_o(result_o));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a request, pass the accept edge, then scramble operands to prove they were latched.
    task automatic issue(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        enable_i = 1'b1; operator_i = op; operand_a_i = a; operand_b_i = b;
        @(posedge clk); #1;
        enable_i = 1'b0; operand_a_i = 32'hDEAD_BEEF; operand_b_i = 32'h1234_5678;
    endtask

    // Edges after the accept edge until valid_o (1 == visible in cycle N+1); 100 on timeout.
    task automatic wait_valid(output int n);
        n = 1;
        while (!valid_o && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!valid_o) n = 100;
    endtask

    task automatic run(input string tag, input logic [6:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res);
        issue(op, a, b);
        wait_valid(lat);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_res"}, result_o, exp_res);
        @(posedge clk); #1;
        chk({tag, "_ready_after"}, {31'd0, ready_o}, 32'd1);
        chk({tag, "_valid_after"}, {31'd0, valid_o}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; enable_i = 1'b0; operator_i = '0; operand_a_i = '0; operand_b_i = '0;
        kill_i = 1'b0; ex_ready_i = 1'b1;
        #12;
        chk("rst_ready",  {31'd0, ready_o}, 32'd1);
        chk("rst_valid",  {31'd0, valid_o}, 32'd0);
        chk("rst_result", result_o, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // non-divide operator is ignored
        issue(7'b0011000, 32'd9, 32'd3);
        chk("ignore_ready", {31'd0, ready_o}, 32'd1);
        chk("ignore_valid", {31'd0, valid_o}, 32'd0);

        // kill in IDLE blocks acceptance
        @(negedge clk); kill_i = 1'b1;
        issue(ALU_DIVU, 32'd9, 32'd3);
        kill_i = 1'b0;
        chk("kill_idle_ready", {31'd0, ready_o}, 32'd1);

        run("divu_100_7",  ALU_DIVU, 32'd100, 32'd7, 33, 32'd14);
        run("rem_m7_2",    ALU_REM,  32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF);
        run("div_m7_2",    ALU_DIV,  32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD);
        run("div_m100_m7", ALU_DIV,  32'hFFFF_FF9C, 32'hFFFF_FFF9, 33, 32'd14);
        run("divu_big",    ALU_DIVU, 32'hFFFF_FFFF, 32'd16, 33, 32'h0FFF_FFFF);
        run("div_55_0",    ALU_DIV,  32'd55, 32'd0, 1, 32'hFFFF_FFFF);
        run("remu_55_0",   ALU_REMU, 32'd55, 32'd0, 1, 32'd55);
        run("div_ovf",     ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
        run("rem_ovf",     ALU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0);

        // backpressure: result held for 5 cycles while EX stalls
        ex_ready_i = 1'b0;
        issue(ALU_DIVU, 32'd1000, 32'd10);
        wait_valid(lat);
        chk("bp_lat", lat, 33);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid_hold", {31'd0, valid_o}, 32'd1);
            chk("bp_result_hold", result_o, 32'd100);
            chk("bp_ready_low", {31'd0, ready_o}, 32'd0);
            @(posedge clk); #1;
        end
        ex_ready_i = 1'b1;
        chk("bp_valid_last", {31'd0, valid_o}, 32'd1);
        @(posedge clk); #1;
        chk("bp_idle_ready", {31'd0, ready_o}, 32'd1);
        chk("bp_idle_valid", {31'd0, valid_o}, 32'd0);

        // kill at cycle N+10
        issue(ALU_DIVU, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #1 kill_i = 1'b1;
        @(posedge clk); #1;
        kill_i = 1'b0;
        chk("kill_ready", {31'd0, ready_o}, 32'd1);
        begin
            int seen = 0;
            for (int i = 0; i < 40; i++) begin
                if (valid_o) seen++;
                @(posedge clk); #1;
            end
            chk("kill_no_valid", seen, 0);
        end

        // async reset at cycle N+20
        issue(ALU_DIVU, 32'd5000, 32'd7);
        repeat (19) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("areset_ready",  {31'd0, ready_o}, 32'd1);
        chk("areset_valid",  {31'd0, valid_o}, 32'd0);
        chk("areset_result", result_o, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        begin
            int seen = 0;
            for (int i = 0; i < 20; i++) begin
                if (valid_o) seen++;
                @(posedge clk); #1;
            end
            chk("areset_no_valid", seen, 0);
        end

        run("remu_17_5", ALU_REMU, 32'd17, 32'd5, 33, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
